ch_gain_cal_div_34s_17ns_16s_seq: RTL and testbench



---
 rtl/ch_gain_cal_div_34s_17ns_16s_seq.sv | 162 ++++++++++++++++
 tb/tb_ch_gain_cal_div_34s_17ns_16s_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ch_gain_cal_div_34s_17ns_16s_seq.sv
// Sequential restoring divider: signed 34-bit dividend / unsigned 17-bit divisor -> saturated signed 16-bit quotient + remainder.
// Latency: accept at edge T, result valid from cycle T+35 (34 ce-high steps); one division in flight.
// Backpressure: result held until out_ready; a new operand set may enter in the same cycle the result leaves; ce low freezes everything.
//
// Ports:
//   clk, rst_n (sync, active-low), ce (global clock enable)
//   in_valid/in_ready + dividend/divisor : operand handshake
//   out_valid/out_ready + quotient/remainder/sat/div_by_zero : registered result handshake
module ch_gain_cal_div_34s_17ns_16s_seq #(
  parameter int DIVIDEND_WIDTH = 34,
  parameter int DIVISOR_WIDTH  = 17,
  parameter int QUOTIENT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH:0]    remainder,
  output logic                      sat,
  output logic                      div_by_zero
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int RW = VW + 1;
  localparam int CW = $clog2(DW + 1);

  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
  localparam logic [DW-1:0] POS_LIMIT = DW'(2**(QW-1) - 1);
  localparam logic [DW-1:0] NEG_LIMIT = DW'(2**(QW-1));
  localparam logic [QW-1:0] Q_MAX     = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN     = {1'b1, {(QW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  step;
  logic           neg;        // dividend sign
  logic           zero_dvd;   // dividend was exactly 0 (needed for x/0)
  logic [DW-1:0]  mag;        // dividend magnitude, consumed MSB first
  logic [VW-1:0]  dvs;
  // The kept partial remainder is always below the divisor, so VW bits hold it;
  // only the freshly shifted value needs the extra bit.
  logic [VW-1:0]  prem;
  logic [DW-2:0]  qacc;       // quotient bits so far; the last step adds the final bit

  logic           accept_in, accept_out;
  logic [RW-1:0]  rem_shift, rem_next;
  logic [RW:0]    trial;
  logic           qbit;
  logic [DW-1:0]  q_next;
  logic [QW-1:0]  res_q;
  logic [RW-1:0]  res_r;
  logic           res_sat, res_dbz;

  // Handshake and next-state logic.
  always_comb begin
    state_next = state;
    out_valid  = (state == DONE);
    in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    accept_in  = ce && in_valid && in_ready;
    accept_out = ce && out_valid && out_ready;
    case (state)
      IDLE: if (accept_in) state_next = BUSY;
      BUSY: if (ce && step == LAST_STEP) state_next = DONE;
      DONE: if (accept_out) state_next = accept_in ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, trial-subtract, keep if non-negative.
  always_comb begin
    rem_shift = {prem, mag[DW-1]};
    trial     = {1'b0, rem_shift} - {2'b00, dvs};
    qbit      = ~trial[RW];
    rem_next  = qbit ? trial[RW-1:0] : rem_shift;
    q_next    = {qacc, qbit};
  end

  // Final sign restore and saturation, evaluated on the last step and registered with the DONE transition.
  always_comb begin
    res_q   = '0;
    res_r   = '0;
    res_sat = 1'b0;
    res_dbz = 1'b0;
    if (dvs == '0) begin
      res_dbz = 1'b1;
      if (zero_dvd) begin
        res_q = '0;
      end else begin
        res_q   = neg ? Q_MIN : Q_MAX;
        res_sat = 1'b1;
      end
    end else begin
      res_r = neg ? ('0 - rem_next) : rem_next;
      if (neg) begin
        // -2^(QW-1) is representable, so only magnitudes beyond it saturate.
        if (q_next > NEG_LIMIT) begin
          res_q   = Q_MIN;
          res_sat = 1'b1;
        end else begin
          res_q = '0 - q_next[QW-1:0];
        end
      end else begin
        if (q_next > POS_LIMIT) begin
          res_q   = Q_MAX;
          res_sat = 1'b1;
        end else begin
          res_q = q_next[QW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      neg         <= 1'b0;
      zero_dvd    <= 1'b0;
      mag         <= '0;
      dvs         <= '0;
      prem        <= '0;
      qacc        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      sat         <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      state <= state_next;
      if (accept_in) begin
        neg      <= dividend[DW-1];
        zero_dvd <= (dividend == '0);
        // Two's-complement negate: -2^(DW-1) maps to 2^(DW-1) as unsigned.
        mag      <= dividend[DW-1] ? ('0 - dividend) : dividend;
        dvs      <= divisor;
        prem     <= '0;
        qacc     <= '0;
        step     <= '0;
      end else if (state == BUSY) begin
        mag  <= {mag[DW-2:0], 1'b0};
        prem <= rem_next[VW-1:0];
        qacc <= q_next[DW-2:0];
        step <= step + CW'(1);
        if (step == LAST_STEP) begin
          quotient    <= res_q;
          remainder   <= res_r;
          sat         <= res_sat;
          div_by_zero <= res_dbz;
        end
      end
    end
  end

endmodule

// File: tb/tb_ch_gain_cal_div_34s_17ns_16s_seq.sv
module tb_ch_gain_cal_div_34s_17ns_16s_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [33:0] dividend = '0;
  logic [16:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] quotient;
  logic [17:0] remainder;
  logic        sat;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  ch_gain_cal_div_34s_17ns_16s_seq dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .sat(sat), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division (truncating, remainder follows dividend), then clamp.
  function automatic void ref_div(input longint a, input longint b,
                                  output logic [15:0] q, output logic [17:0] r,
                                  output logic s, output logic z);
    longint qq, rr;
    z = (b == 0);
    s = 1'b0;
    r = '0;
    q = '0;
    if (b == 0) begin
      if (a > 0)      begin q = 16'h7fff; s = 1'b1; end
      else if (a < 0) begin q = 16'h8000; s = 1'b1; end
    end else begin
      qq = a / b;
      rr = a % b;
      r  = rr[17:0];
      if (qq > 32767)       begin q = 16'h7fff; s = 1'b1; end
      else if (qq < -32768) begin q = 16'h8000; s = 1'b1; end
      else                  q = qq[15:0];
    end
  endfunction

  // Drives one operand set (starting after a negedge, DUT idle), returns the result and cycles to out_valid.
  task automatic run_op(input longint a, input longint b,
                        output logic [15:0] q, output logic [17:0] r,
                        output logic s, output logic z, output int lat);
    q = 'x; r = 'x; s = 1'bx; z = 1'bx; lat = 999;
    ce = 1'b1; out_ready = 1'b1;
    dividend = a[33:0]; divisor = b[16:0]; in_valid = 1'b1;
    #1;
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    q = quotient; r = remainder; s = sat; z = div_by_zero;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if ({out_valid, in_ready, quotient, remainder, sat, div_by_zero} !== {1'b0, 1'b1, 34'd0, 2'b00}) begin
      fails++;
      $display("FAIL reset: ov=%b ir=%b q=%h r=%h s=%b z=%b, want ov=0 ir=1 q=0 r=0 s=0 z=0",
               out_valid, in_ready, quotient, remainder, sat, div_by_zero);
    end
  endtask

  task automatic test_basic();
    logic [15:0] q; logic [17:0] r; logic s, z; int lat;
    run_op(1000, 7, q, r, s, z, lat);
    tests++;
    if (lat !== 35) begin fails++; $display("FAIL basic_latency: got %0d want 35", lat); end
    tests++;
    if ({q, r, s, z} !== {16'd142, 18'd6, 2'b00}) begin
      fails++;
      $display("FAIL basic_pos: got q=%0d r=%0d s=%b z=%b want q=142 r=6 s=0 z=0", $signed(q), $signed(r), s, z);
    end
    run_op(-1000, 7, q, r, s, z, lat);
    tests++;
    if ({q, r, s, z} !== {-16'sd142, -18'sd6, 2'b00} || lat !== 35) begin
      fails++;
      $display("FAIL basic_neg: got q=%0d r=%0d s=%b z=%b lat=%0d want q=-142 r=-6 s=0 z=0 lat=35",
               $signed(q), $signed(r), s, z, lat);
    end
  endtask

  task automatic test_table(input string name, input longint ta[], input longint tb_[]);
    logic [15:0] q, eq; logic [17:0] r, er; logic s, z, es, ez; int lat;
    for (int i = 0; i < ta.size(); i++) begin
      run_op(ta[i], tb_[i], q, r, s, z, lat);
      ref_div(ta[i], tb_[i], eq, er, es, ez);
      tests++;
      if ({q, r, s, z} !== {eq, er, es, ez} || lat !== 35) begin
        fails++;
        $display("FAIL %s[%0d] %0d/%0d: got q=%0d r=%0d s=%b z=%b lat=%0d want q=%0d r=%0d s=%b z=%b lat=35",
                 name, i, ta[i], tb_[i], $signed(q), $signed(r), s, z, lat, $signed(eq), $signed(er), es, ez);
      end
    end
  endtask

  task automatic test_saturation();
    longint ta[] = '{64'sd8589934591, -64'sd8589934592, -64'sd32768, 64'sd32768, -64'sd32769};
    longint tb_[] = '{64'sd1, 64'sd1, 64'sd1, 64'sd1, 64'sd1};
    test_table("saturation", ta, tb_);
  endtask

  task automatic test_div_zero();
    longint ta[] = '{64'sd5, -64'sd5, 64'sd0};
    longint tb_[] = '{64'sd0, 64'sd0, 64'sd0};
    test_table("div_zero", ta, tb_);
  endtask

  task automatic test_random();
    longint ta[] = new[40];
    longint tb_[] = new[40];
    logic [33:0] d;
    longint b, qt;
    for (int i = 0; i < 40; i++) begin
      b = longint'($urandom_range(1, 131071));
      if (i % 2 == 0) begin
        d = {2'($urandom), 32'($urandom)};
        ta[i] = longint'($signed(d));
      end else begin
        // Quotient near the saturation boundary, random remainder.
        qt = longint'($urandom_range(0, 70000)) - 35000;
        ta[i] = qt * b + (qt < 0 ? -1 : 1) * longint'($urandom_range(0, 32'(b - 1)));
      end
      if (i % 13 == 5) b = longint'($urandom_range(1, 3));
      tb_[i] = b;
    end
    test_table("random", ta, tb_);
  endtask

  task automatic test_back_to_back();
    int lat;
    ce = 1'b1; out_ready = 1'b0;
    dividend = 34'd1000; divisor = 17'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 34'd300; divisor = 17'd3;
    lat = 999;
    for (int i = 1; i <= 200; i++) begin
      if (out_valid) begin lat = i; break; end
      @(negedge clk);
    end
    tests++;
    if (lat !== 35) begin fails++; $display("FAIL bp_first_latency: got %0d want 35", lat); end
    for (int k = 0; k < 10; k++) begin
      #1;
      tests++;
      if ({in_ready, out_valid, quotient, remainder, sat, div_by_zero} !== {1'b0, 1'b1, 16'd142, 18'd6, 2'b00}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got ir=%b ov=%b q=%0d r=%0d want ir=0 ov=1 q=142 r=6",
                 k, in_ready, out_valid, $signed(quotient), $signed(remainder));
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 999;
    for (int i = 1; i <= 200; i++) begin
      if (out_valid) begin lat = i; break; end
      @(negedge clk);
    end
    tests++;
    if (lat !== 35 || quotient !== 16'd100 || remainder !== 18'd0) begin
      fails++;
      $display("FAIL bp_second: got lat=%0d q=%0d r=%0d want lat=35 q=100 r=0", lat, $signed(quotient), $signed(remainder));
    end
    @(negedge clk);
  endtask

  task automatic test_ce_gating();
    int hi;
    logic seen_valid;
    ce = 1'b1; out_ready = 1'b1;
    dividend = 34'd123456; divisor = 17'd789; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      if (out_valid) break;
      ce = ($urandom_range(0, 1) == 1);
      if (ce) hi++;
      @(negedge clk);
    end
    ce = 1'b0;
    tests++;
    if (hi !== 34 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL ce_steps: got %0d ce-high steps (ov=%b) want 34 (ov=1)", hi, out_valid);
    end
    tests++;
    if ({quotient, remainder, sat, div_by_zero} !== {16'd156, 18'd372, 2'b00}) begin
      fails++;
      $display("FAIL ce_result: got q=%0d r=%0d s=%b z=%b want q=156 r=372 s=0 z=0",
               $signed(quotient), $signed(remainder), sat, div_by_zero);
    end
    // ce low in DONE with out_ready high: nothing may move.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || quotient !== 16'd156 || remainder !== 18'd372) begin
        fails++;
        $display("FAIL ce_hold[%0d]: got ov=%b q=%0d r=%0d want ov=1 q=156 r=372", k, out_valid, $signed(quotient), $signed(remainder));
      end
    end
    ce = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL ce_release: got ov=%b want 0", out_valid); end
    // ce low in IDLE: in_valid is ignored, so no result may ever appear.
    ce = 1'b0; in_valid = 1'b1; dividend = 34'd50; divisor = 17'd5;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; ce = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    tests++;
    if (seen_valid !== 1'b0) begin fails++; $display("FAIL ce_idle_ignore: got a result, want none"); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] q; logic [17:0] r; logic s, z; int lat;
    ce = 1'b1; out_ready = 1'b1;
    dividend = 34'd777777; divisor = 17'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if ({out_valid, in_ready, quotient, remainder, sat, div_by_zero} !== {1'b0, 1'b1, 34'd0, 2'b00}) begin
      fails++;
      $display("FAIL reset_mid: got ov=%b ir=%b q=%h r=%h s=%b z=%b want ov=0 ir=1 zeros",
               out_valid, in_ready, quotient, remainder, sat, div_by_zero);
    end
    @(negedge clk);
    run_op(50, 5, q, r, s, z, lat);
    tests++;
    if ({q, r, s, z} !== {16'd10, 18'd0, 2'b00} || lat !== 35) begin
      fails++;
      $display("FAIL reset_mid_next: got q=%0d r=%0d s=%b z=%b lat=%0d want q=10 r=0 s=0 z=0 lat=35",
               $signed(q), $signed(r), s, z, lat);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_basic();
    test_saturation();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_ce_gating();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
